// File: rtl/glb_pkg.sv
// glb_pkg: shared constants and helpers for the global buffer SRAM.
//   BANKS      number of interleaved byte banks
//   EN_*       legal lane-enable codes (contiguous from lane 0)
//   lane_cnt   number of active lanes for an enable code (0 for illegal codes)
//   bank_of    bank hit by lane k of an access whose address ends in addr[1:0]
package glb_pkg;

  localparam int BANKS = 4;

  localparam logic [3:0] EN_NONE = 4'b0000;
  localparam logic [3:0] EN_1    = 4'b0001;
  localparam logic [3:0] EN_2    = 4'b0011;
  localparam logic [3:0] EN_3    = 4'b0111;
  localparam logic [3:0] EN_4    = 4'b1111;

  function automatic logic [2:0] lane_cnt(input logic [3:0] en);
    case (en)
      EN_1:    return 3'd1;
      EN_2:    return 3'd2;
      EN_3:    return 3'd3;
      EN_4:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] bank_of(input logic [1:0] addr, input logic [1:0] k);
    return addr + k;
  endfunction

endpackage

// File: rtl/glb_byte_bank.sv
// glb_byte_bank: one byte-wide 1R1W bank of the global buffer.
//   clk     clock
//   we      write enable
//   w_row   write row
//   w_data  write byte
//   r_row   read row (read every cycle)
//   r_data  registered read byte; a same-row write in the same cycle
//           returns the old contents
module glb_byte_bank #(
  parameter int ROWS       = 1024,
  parameter int ROW_W      = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ROW_W-1:0]      w_row,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ROW_W-1:0]      r_row,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_row] <= w_data;
    end
    r_data <= mem[r_row];
  end

endmodule

// File: rtl/glb_sram.sv
// glb_sram: dual-port global buffer built from four interleaved byte banks.
//   Port A (a_*) is always granted. Port B (b_*) is granted per direction
//   only when none of its banks is used by A in the same direction.
//   a_re/b_re, a_we/b_we   lane enables (0000/0001/0011/0111/1111)
//   *_r_addr, *_w_addr     byte addresses (unaligned allowed)
//   *_r_data, *_rvalid     read response, one cycle after the request
//   *_w_data               write data, lane k -> byte addr+k
//   b_rgnt, b_wgnt         combinational grants for port B
module glb_sram
  import glb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              a_re,
  input  logic [ADDR_WIDTH-1:0]   a_r_addr,
  output logic [DATA_WIDTH*4-1:0] a_r_data,
  output logic                    a_rvalid,
  input  logic [3:0]              a_we,
  input  logic [ADDR_WIDTH-1:0]   a_w_addr,
  input  logic [DATA_WIDTH*4-1:0] a_w_data,
  input  logic [3:0]              b_re,
  input  logic [ADDR_WIDTH-1:0]   b_r_addr,
  output logic [DATA_WIDTH*4-1:0] b_r_data,
  output logic                    b_rvalid,
  input  logic [3:0]              b_we,
  input  logic [ADDR_WIDTH-1:0]   b_w_addr,
  input  logic [DATA_WIDTH*4-1:0] b_w_data,
  output logic                    b_rgnt,
  output logic                    b_wgnt
);

  localparam int ROWS  = DEPTH / BANKS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

  // Request index: 0 = A read, 1 = A write, 2 = B read, 3 = B write.
  logic [ADDR_WIDTH-1:0] req_addr [4];
  logic [3:0]            req_en   [4];
  logic [2:0]            req_n    [4];
  logic [BANKS-1:0]      req_use  [4];
  logic [1:0]            req_lane [4][BANKS];
  logic [ROW_W-1:0]      req_row  [4][BANKS];

  assign req_addr[0] = a_r_addr;
  assign req_addr[1] = a_w_addr;
  assign req_addr[2] = b_r_addr;
  assign req_addr[3] = b_w_addr;
  assign req_en[0]   = a_re;
  assign req_en[1]   = a_we;
  assign req_en[2]   = b_re;
  assign req_en[3]   = b_we;

  function automatic logic [DATA_WIDTH-1:0] lane_sel(input logic [DATA_WIDTH*4-1:0] d,
                                                     input logic [1:0] k);
    return d[k*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Rotation: bank j is touched by lane (j - addr[1:0]) mod 4. The bank is
  // used only if that lane is enabled and its byte lies inside the memory;
  // out-of-range lanes claim no bank, so they never block the other port.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      assign req_n[gi] = lane_cnt(req_en[gi]);
      for (gj = 0; gj < BANKS; gj++) begin : g_bank
        logic [ADDR_WIDTH:0] byte_addr;
        assign req_lane[gi][gj]   = 2'(gj) - req_addr[gi][1:0];
        assign byte_addr          = {1'b0, req_addr[gi]} + (ADDR_WIDTH+1)'(req_lane[gi][gj]);
        assign req_use[gi][gj]    = ({1'b0, req_lane[gi][gj]} < req_n[gi]) && (byte_addr < DEPTH_X);
        assign req_row[gi][gj]    = byte_addr[ROW_W+1:2];
      end
    end
  endgenerate

  // A bank-level overlap also covers every same-byte case, so a denied B
  // write can never race an A write to the same location.
  assign b_rgnt = (req_n[2] != 3'd0) && ((req_use[0] & req_use[2]) == '0);
  assign b_wgnt = (req_n[3] != 3'd0) && ((req_use[1] & req_use[3]) == '0);

  logic [DATA_WIDTH-1:0] bank_rdata [BANKS];

  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_mem
      logic                  a_wr;
      logic                  b_wr;
      logic                  bank_we;
      logic [ROW_W-1:0]      w_row;
      logic [ROW_W-1:0]      r_row;
      logic [DATA_WIDTH-1:0] w_data;

      assign a_wr    = req_use[1][gi];
      assign b_wr    = b_wgnt && req_use[3][gi];
      assign bank_we = !rst && (a_wr || b_wr);
      assign w_row   = a_wr ? req_row[1][gi] : req_row[3][gi];
      assign w_data  = a_wr ? lane_sel(a_w_data, req_lane[1][gi])
                            : lane_sel(b_w_data, req_lane[3][gi]);
      // A granted B read never shares a bank with A's read.
      assign r_row   = req_use[0][gi] ? req_row[0][gi] : req_row[2][gi];

      glb_byte_bank #(
        .ROWS       (ROWS),
        .ROW_W      (ROW_W),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
        .clk    (clk),
        .we     (bank_we),
        .w_row  (w_row),
        .w_data (w_data),
        .r_row  (r_row),
        .r_data (bank_rdata[gi])
      );
    end
  endgenerate

  // Per-lane "this lane returns real data" flags and the low address bits
  // needed to de-rotate bank outputs back into lane order.
  logic [3:0] a_lane_reg;
  logic [3:0] b_lane_reg;
  logic [1:0] a_lo_reg;
  logic [1:0] b_lo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_lane_reg <= '0;
      b_lane_reg <= '0;
      a_lo_reg   <= '0;
      b_lo_reg   <= '0;
    end else begin
      a_rvalid <= (req_n[0] != 3'd0);
      b_rvalid <= b_rgnt;
      a_lo_reg <= a_r_addr[1:0];
      b_lo_reg <= b_r_addr[1:0];
      for (int k = 0; k < 4; k++) begin
        a_lane_reg[k] <= req_use[0][bank_of(a_r_addr[1:0], 2'(k))];
        b_lane_reg[k] <= b_rgnt && req_use[2][bank_of(b_r_addr[1:0], 2'(k))];
      end
    end
  end

  always_comb begin
    a_r_data = '0;
    b_r_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (a_lane_reg[k]) begin
        a_r_data[k*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[bank_of(a_lo_reg, 2'(k))];
      end
      if (b_lane_reg[k]) begin
        b_r_data[k*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[bank_of(b_lo_reg, 2'(k))];
      end
    end
  end

endmodule

// File: tb/tb_glb_sram.sv
module tb_glb_sram;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  a_re = '0, a_we = '0, b_re = '0, b_we = '0;
  logic [31:0] a_r_addr = '0, a_w_addr = '0, a_w_data = '0;
  logic [31:0] b_r_addr = '0, b_w_addr = '0, b_w_data = '0;
  logic [31:0] a_r_data, b_r_data;
  logic        a_rvalid, b_rvalid, b_rgnt, b_wgnt;

  always #5 clk = ~clk;

  glb_sram #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_re(a_re), .a_r_addr(a_r_addr), .a_r_data(a_r_data), .a_rvalid(a_rvalid),
    .a_we(a_we), .a_w_addr(a_w_addr), .a_w_data(a_w_data),
    .b_re(b_re), .b_r_addr(b_r_addr), .b_r_data(b_r_data), .b_rvalid(b_rvalid),
    .b_we(b_we), .b_w_addr(b_w_addr), .b_w_data(b_w_data),
    .b_rgnt(b_rgnt), .b_wgnt(b_wgnt)
  );

  // Byte-level reference memory and expected outputs.
  logic [7:0]  mdl [DEPTH];
  logic        exp_rgnt = 1'b0, exp_wgnt = 1'b0;
  logic        exp_a_valid = 1'b0, exp_b_valid = 1'b0;
  logic [31:0] exp_a_data = '0, exp_b_data = '0;
  logic        chk_en = 1'b0;
  logic        seen_rgnt, seen_wgnt;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int ncnt(input logic [3:0] e);
    case (e)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b0111: return 3;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  // Banks holding the in-range bytes addr..addr+n-1.
  function automatic logic [3:0] banks(input logic [31:0] addr, input int n);
    logic [3:0] m = '0;
    longint unsigned ba;
    for (int k = 0; k < n; k++) begin
      ba = 64'(addr) + 64'(k);
      if (ba < 64'(DEPTH)) m[ba % 4] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] read_val(input logic [31:0] addr, input int n);
    logic [31:0] v = '0;
    longint unsigned ba;
    for (int k = 0; k < n; k++) begin
      ba = 64'(addr) + 64'(k);
      if (ba < 64'(DEPTH)) v[8*k +: 8] = mdl[ba];
    end
    return v;
  endfunction

  task automatic write_bytes(input logic [31:0] addr, input int n, input logic [31:0] d);
    longint unsigned ba;
    for (int k = 0; k < n; k++) begin
      ba = 64'(addr) + 64'(k);
      if (ba < 64'(DEPTH)) mdl[ba] = d[8*k +: 8];
    end
  endtask

  // One clock cycle: drive, predict, sample grants, cross the edge, update model.
  task automatic step(input logic r,
                      input logic [3:0] are, input logic [31:0] ara,
                      input logic [3:0] awe, input logic [31:0] awa, input logic [31:0] awd,
                      input logic [3:0] bre, input logic [31:0] bra,
                      input logic [3:0] bwe, input logic [31:0] bwa, input logic [31:0] bwd,
                      input string tag);
    logic [31:0] nxt_a_data, nxt_b_data;
    logic        nxt_a_valid, nxt_b_valid;
    int na, nb;
    rst = r;
    a_re = are; a_r_addr = ara; a_we = awe; a_w_addr = awa; a_w_data = awd;
    b_re = bre; b_r_addr = bra; b_we = bwe; b_w_addr = bwa; b_w_data = bwd;
    na = ncnt(are);
    nb = ncnt(bre);
    exp_rgnt = (nb > 0) && ((banks(ara, na) & banks(bra, nb)) == 4'b0);
    exp_wgnt = (ncnt(bwe) > 0) && ((banks(awa, ncnt(awe)) & banks(bwa, ncnt(bwe))) == 4'b0);
    if (r) begin
      nxt_a_data = '0; nxt_b_data = '0; nxt_a_valid = 1'b0; nxt_b_valid = 1'b0;
    end else begin
      nxt_a_valid = (na > 0);
      nxt_a_data  = read_val(ara, na);
      nxt_b_valid = exp_rgnt;
      nxt_b_data  = exp_rgnt ? read_val(bra, nb) : 32'h0;
    end
    @(negedge clk);
    seen_rgnt = b_rgnt;
    seen_wgnt = b_wgnt;
    @(posedge clk);
    #1;
    if (!r) begin
      write_bytes(awa, ncnt(awe), awd);
      if (exp_wgnt) write_bytes(bwa, ncnt(bwe), bwd);
    end
    exp_a_data = nxt_a_data; exp_a_valid = nxt_a_valid;
    exp_b_data = nxt_b_data; exp_b_valid = nxt_b_valid;
    chk_en = 1'b1;
    if (tag != "")
      $display("[%0t] %-12s rst=%0b A r%b@%h w%b@%h B r%b@%h w%b@%h gnt r%0b w%0b -> a=%h/%0b b=%h/%0b",
               $time, tag, r, are, ara, awe, awa, bre, bra, bwe, bwa, seen_rgnt, seen_wgnt,
               a_r_data, a_rvalid, b_r_data, b_rvalid);
  endtask

  // Single compare process: every cycle, grants and the read responses.
  always @(negedge clk) begin
    if (chk_en) begin
      check("b_rgnt",   32'(b_rgnt),   32'(exp_rgnt));
      check("b_wgnt",   32'(b_wgnt),   32'(exp_wgnt));
      check("a_rvalid", 32'(a_rvalid), 32'(exp_a_valid));
      check("a_r_data", a_r_data,      exp_a_data);
      check("b_rvalid", 32'(b_rvalid), 32'(exp_b_valid));
      check("b_r_data", b_r_data,      exp_b_data);
    end
  end

  function automatic logic [3:0] rnd_en();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    return 4'b0000;
      2:       return 4'b0001;
      3:       return 4'b0011;
      4:       return 4'b0111;
      5:       return r[3:0];
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 19) == 0) return 32'(DEPTH - 4 + $urandom_range(0, 7));
    return 32'($urandom_range(0, 31));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tmp;
    logic [3:0]  bre_h, bwe_h;
    logic [31:0] bra_h, bwa_h, bwd_h;
    logic        hold_r, hold_w;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    check("rst_a_data",  a_r_data, 32'h0);
    check("rst_a_valid", 32'(a_rvalid), 32'h0);
    check("rst_b_data",  b_r_data, 32'h0);
    check("rst_b_valid", 32'(b_rvalid), 32'h0);

    // Fill the whole memory so every byte has a defined value.
    for (int i = 0; i < DEPTH / 4; i++)
      step(0, 0, 0, 4'hF, 32'(i * 4), $urandom, 0, 0, 0, 0, 0, "");

    // Aligned write then read
    step(0, 0, 0, 4'hF, 32'h10, 32'h44332211, 0, 0, 0, 0, 0, "a_wr_align");
    step(0, 4'hF, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, "a_rd_align");
    check("aligned_data",  a_r_data, 32'h44332211);
    check("aligned_valid", 32'(a_rvalid), 32'h1);
    check("model_aligned", exp_a_data, 32'h44332211);

    // Unaligned B write across rows 4-5, partial reads on both ports
    step(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 32'h13, 32'hDDCCBBAA, "b_wr_unal");
    step(0, 4'b0001, 32'h13, 0, 0, 0, 4'b0111, 32'h14, 0, 0, 0, "rd_partial");
    check("b_partial", b_r_data, 32'h00DDCCBB);
    check("a_partial", a_r_data, 32'h000000AA);
    check("model_b_partial", exp_b_data, 32'h00DDCCBB);

    // Read conflict, B holds, then no-conflict pair
    step(0, 4'hF, 32'h20, 0, 0, 0, 4'b0001, 32'h22, 0, 0, 0, "rd_conflict");
    check("conflict_gnt",    32'(seen_rgnt), 32'h0);
    check("conflict_bvalid", 32'(b_rvalid),  32'h0);
    step(0, 0, 0, 0, 0, 0, 4'b0001, 32'h22, 0, 0, 0, "b_hold");
    check("hold_gnt",    32'(seen_rgnt), 32'h1);
    check("hold_bvalid", 32'(b_rvalid),  32'h1);
    step(0, 4'b0001, 32'h20, 0, 0, 0, 4'b0001, 32'h21, 0, 0, 0, "rd_no_confl");
    check("noconf_gnt",    32'(seen_rgnt), 32'h1);
    check("noconf_avalid", 32'(a_rvalid),  32'h1);

    // Read-during-write returns old byte
    step(0, 0, 0, 4'b0001, 32'h30, 32'h5A, 0, 0, 0, 0, 0, "wr_5a");
    step(0, 0, 0, 4'b0001, 32'h30, 32'h77, 4'b0001, 32'h30, 0, 0, 0, "rdw");
    check("rdw_old", b_r_data, 32'h0000005A);
    step(0, 0, 0, 0, 0, 0, 4'b0001, 32'h30, 0, 0, 0, "rdw_reread");
    check("rdw_new", b_r_data, 32'h00000077);

    // Illegal write enable leaves memory untouched
    step(0, 0, 0, 4'b0101, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 0, 0, "a_we_illeg");
    step(0, 4'b0111, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, "rd_after_il");
    check("illegal_we", a_r_data, 32'h00332211);

    // Out-of-range upper lanes
    step(0, 4'hF, 32'(DEPTH - 2), 0, 0, 0, 0, 0, 0, 0, 0, "rd_oob");
    tmp = a_r_data;
    check("oob_upper", 32'(tmp[31:16]), 32'h0);
    check("oob_valid", 32'(a_rvalid), 32'h1);

    // No read
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    check("idle_data",  a_r_data, 32'h0);
    check("idle_valid", 32'(a_rvalid), 32'h0);

    // Reset in the middle of a read and a write
    step(1, 4'b0111, 32'h10, 4'hF, 32'h10, 32'hDEADBEEF, 4'hF, 32'h40, 0, 0, 0, "rst_mid");
    check("rstmid_a_data",  a_r_data, 32'h0);
    check("rstmid_a_valid", 32'(a_rvalid), 32'h0);
    check("rstmid_b_valid", 32'(b_rvalid), 32'h0);
    step(0, 4'b0111, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst_rd");
    check("retained", a_r_data, 32'h00332211);

    // Randomized traffic, B holding stalled requests until granted
    hold_r = 1'b0; hold_w = 1'b0;
    bre_h = '0; bra_h = '0; bwe_h = '0; bwa_h = '0; bwd_h = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold_r) begin bre_h = rnd_en(); bra_h = rnd_addr(); end
      if (!hold_w) begin bwe_h = rnd_en(); bwa_h = rnd_addr(); bwd_h = $urandom; end
      step(($urandom_range(0, 99) == 0), rnd_en(), rnd_addr(), rnd_en(), rnd_addr(), $urandom,
           bre_h, bra_h, bwe_h, bwa_h, bwd_h, "");
      hold_r = (ncnt(bre_h) > 0) && !exp_rgnt;
      hold_w = (ncnt(bwe_h) > 0) && !exp_wgnt;
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
